// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display tile fetches take the single-port RAM with
// absolute priority, the draw engine gets every remaining cycle.
module vga_fb_arbiter #(
   parameter int TILECOLS = 200,
   parameter int TILEROWS = 150,
   parameter int VLAST    = 665
) (
   input  logic        CLK_100MHz,
   input  logic        Reset,
   input  logic [10:0] CurrentX,
   input  logic [10:0] CurrentY,
   input  logic        HBlank,
   input  logic        VBlank,
   input  logic        DrawReq,
   input  logic [14:0] DrawAddr,
   input  logic        DrawWe,
   input  logic [7:0]  DrawWrData,
   output logic        DrawAck,
   output logic        DrawRdValid,
   output logic [7:0]  DrawRdData,
   output logic [14:0] FbAddr,
   output logic        FbWe,
   output logic [7:0]  FbWrData,
   input  logic [7:0]  FbRdData,
   output logic [7:0]  PixelColor,
   output logic        FrameStart
);

   localparam logic [9:0]  TC = 10'(TILECOLS);
   localparam logic [9:0]  TR = 10'(TILEROWS);
   localparam logic [10:0] VL = 11'(VLAST);

   // Framebuffer rows are 200 tiles wide: r*200 = r*128 + r*64 + r*8.
   function automatic logic [14:0] times200(input logic [8:0] r);
      logic [14:0] rw;
      rw = {6'b0, r};
      return (rw << 7) + (rw << 6) + (rw << 3);
   endfunction

   logic [8:0]  prev_col_q;
   logic        hblank_q, vblank_q;
   logic        disp_rd_pend_q;
   logic [7:0]  next_word_q;
   logic [7:0]  pixel_q, pixel_d;
   logic        draw_rd_valid_q, draw_rd_valid_d;
   logic        frame_start_q, frame_start_d;

   logic [8:0]  col, row;
   logic [9:0]  col_p1, pre_row;
   logic [11:0] y_p1;
   logic [14:0] disp_addr;
   logic        tile_chg, active, in_range, act_evt, hb_rise, y_last, pre_evt, disp_evt;
   logic        unused_x;

   assign unused_x  = ^CurrentX[1:0];
   assign col       = CurrentX[10:2];
   assign row       = CurrentY[10:2];
   assign tile_chg  = (col != prev_col_q);
   assign active    = !HBlank && !VBlank;
   assign col_p1    = {1'b0, col} + 10'd1;
   assign in_range  = ({1'b0, col} < TC) && ({1'b0, row} < TR);
   assign act_evt   = tile_chg && active && (col_p1 < TC) && ({1'b0, row} < TR);

   // Entering horizontal blanking prefetches column 0 of the next line's row.
   assign hb_rise   = HBlank && !hblank_q;
   assign y_last    = (CurrentY == VL);
   assign y_p1      = {1'b0, CurrentY} + 12'd1;
   assign pre_row   = y_last ? 10'd0 : y_p1[11:2];
   assign pre_evt   = hb_rise && ((CurrentY < 11'd599) || y_last) && (pre_row < TR);

   assign disp_evt  = !Reset && (act_evt || pre_evt);
   assign disp_addr = act_evt ? (times200(row) + {5'b0, col_p1}) : times200(pre_row[8:0]);

   always_comb begin
      FbAddr   = '0;
      FbWe     = 1'b0;
      FbWrData = '0;
      DrawAck  = 1'b0;
      if (disp_evt) begin
         FbAddr = disp_addr;
      end else if (!Reset && DrawReq) begin
         FbAddr   = DrawAddr;
         FbWe     = DrawWe;
         FbWrData = DrawWrData;
         DrawAck  = 1'b1;
      end
   end

   always_comb begin
      pixel_d = pixel_q;
      if (!active || !in_range) begin
         pixel_d = '0;
      end else if (tile_chg) begin
         pixel_d = next_word_q;
      end
      draw_rd_valid_d = DrawAck && !DrawWe;
      frame_start_d   = vblank_q && !VBlank;
   end

   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         prev_col_q      <= 9'h1FF;
         hblank_q        <= 1'b0;
         vblank_q        <= 1'b0;
         disp_rd_pend_q  <= 1'b0;
         next_word_q     <= '0;
         pixel_q         <= '0;
         draw_rd_valid_q <= 1'b0;
         frame_start_q   <= 1'b0;
      end else begin
         prev_col_q      <= col;
         hblank_q        <= HBlank;
         vblank_q        <= VBlank;
         disp_rd_pend_q  <= disp_evt;
         if (disp_rd_pend_q) begin
            next_word_q <= FbRdData;
         end
         pixel_q         <= pixel_d;
         draw_rd_valid_q <= draw_rd_valid_d;
         frame_start_q   <= frame_start_d;
      end
   end

   assign DrawRdData  = FbRdData;
   assign DrawRdValid = draw_rd_valid_q;
   assign PixelColor  = pixel_q;
   assign FrameStart  = frame_start_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a cycle model of the fetch/grant rules
// and a registered-read RAM standing in for the framebuffer.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic [10:0] CurrentX = 11'd900;
   logic [10:0] CurrentY = 11'd3;
   logic        HBlank = 1'b0, VBlank = 1'b0;
   logic        DrawReq = 1'b0;
   logic [14:0] DrawAddr = '0;
   logic        DrawWe = 1'b0;
   logic [7:0]  DrawWrData = '0;
   logic        DrawAck, DrawRdValid, FbWe, FrameStart;
   logic [7:0]  DrawRdData, FbWrData, PixelColor;
   logic [14:0] FbAddr;
   logic [7:0]  FbRdData = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int req_cyc = 0;
   int ack_lat = -1;
   int we_cnt = 0;
   bit ack_seen;

   logic [7:0] mem    [0:32767];
   logic [7:0] shadow [0:32767];

   // Model state (values the registered outputs must show after the next edge).
   int m_prev_col = 511;
   bit m_hb = 0, m_vb = 0, m_pend = 0, m_rdv = 0, m_fs = 0;
   int m_nw = 0, m_pix = 0, m_pend_data = 0, m_rd_data = 0;

   vga_fb_arbiter dut (
      .CLK_100MHz (clk),
      .Reset      (Reset),
      .CurrentX   (CurrentX),
      .CurrentY   (CurrentY),
      .HBlank     (HBlank),
      .VBlank     (VBlank),
      .DrawReq    (DrawReq),
      .DrawAddr   (DrawAddr),
      .DrawWe     (DrawWe),
      .DrawWrData (DrawWrData),
      .DrawAck    (DrawAck),
      .DrawRdValid(DrawRdValid),
      .DrawRdData (DrawRdData),
      .FbAddr     (FbAddr),
      .FbWe       (FbWe),
      .FbWrData   (FbWrData),
      .FbRdData   (FbRdData),
      .PixelColor (PixelColor),
      .FrameStart (FrameStart)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (FbWe) mem[FbAddr] <= FbWrData;
      FbRdData <= mem[FbAddr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : model
      int  col, row, prow, eaddr;
      bit  chg, edisp, eack;
      col   = int'(CurrentX) / 4;
      row   = int'(CurrentY) / 4;
      chg   = (col != m_prev_col);
      edisp = 0;
      eaddr = 0;
      if (!Reset) begin
         if (chg && !HBlank && !VBlank && col + 1 < 200 && row < 150) begin
            edisp = 1;
            eaddr = row * 200 + col + 1;
         end else if (HBlank && !m_hb && (CurrentY < 599 || CurrentY == 665)) begin
            prow = (CurrentY == 665) ? 0 : (int'(CurrentY) + 1) / 4;
            if (prow < 150) begin
               edisp = 1;
               eaddr = prow * 200;
            end
         end
      end
      eack = !Reset && !edisp && DrawReq;

      chk("DrawAck", DrawAck, eack);
      chk("FbAddr", FbAddr, edisp ? eaddr : (eack ? int'(DrawAddr) : 0));
      chk("FbWe", FbWe, eack && DrawWe);
      if (!edisp) chk("FbWrData", FbWrData, eack ? int'(DrawWrData) : 0);
      chk("PixelColor", PixelColor, m_pix);
      chk("DrawRdValid", DrawRdValid, m_rdv);
      if (m_rdv) chk("DrawRdData", DrawRdData, m_rd_data);
      chk("FrameStart", FrameStart, m_fs);
      if (FbWe) we_cnt++;

      if (Reset) begin
         m_prev_col = 511;
         m_hb = 0; m_vb = 0; m_pend = 0; m_rdv = 0; m_fs = 0;
         m_nw = 0; m_pix = 0;
      end else begin
         if (HBlank || VBlank || col >= 200 || row >= 150) m_pix = 0;
         else if (chg) m_pix = m_nw;
         if (m_pend) m_nw = m_pend_data;
         m_pend      = edisp;
         m_pend_data = int'(shadow[eaddr]);
         m_rdv       = eack && !DrawWe;
         m_rd_data   = int'(shadow[DrawAddr]);
         if (eack && DrawWe) shadow[DrawAddr] = DrawWrData;
         m_fs        = m_vb && !VBlank;
         m_prev_col  = col;
         m_hb        = HBlank;
         m_vb        = VBlank;
      end
   end

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic adv();
      ack_seen = DrawReq && DrawAck;
      @(posedge clk);
      #1;
      if (ack_seen) begin
         ack_lat = cyc - req_cyc;
         DrawReq = 1'b0;
      end
      cyc++;
   endtask

   task automatic tick();
      neg();
      adv();
   endtask

   task automatic scan(input int x0, input int x1);
      for (int x = x0; x <= x1; x++) begin
         CurrentX = 11'(x);
         tick();
         tick();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".DrawAck"}, DrawAck, 0);
      chk({tag, ".FbWe"}, FbWe, 0);
      chk({tag, ".FbAddr"}, FbAddr, 0);
      chk({tag, ".FbWrData"}, FbWrData, 0);
      chk({tag, ".PixelColor"}, PixelColor, 0);
      chk({tag, ".DrawRdValid"}, DrawRdValid, 0);
      chk({tag, ".FrameStart"}, FrameStart, 0);
   endtask

   initial begin
      for (int a = 0; a < 32768; a++) begin
         mem[a]    = 8'(((a * 37 + 11) % 255) + 1);
         shadow[a] = 8'(((a * 37 + 11) % 255) + 1);
      end

      // Reset with the beam parked beyond the visible columns.
      tick();
      tick();
      neg(); chk_all_zero("reset"); adv();
      Reset = 1'b0;
      tick(); tick(); tick();

      // HBlank rises on line 3: prefetch row 1, column 0.
      HBlank = 1'b1;
      neg(); chk("hb_rise.FbAddr", FbAddr, 200); chk("hb_rise.DrawAck", DrawAck, 0); adv();
      tick(); tick(); tick();

      // Line 4 starts: first tile shows the prefetched word, column 1 is fetched.
      CurrentY = 11'd4; HBlank = 1'b0; CurrentX = 11'd0;
      neg(); chk("line4.FbAddr", FbAddr, 201); adv();
      neg(); chk("line4.Pixel", PixelColor, 17); adv();
      scan(1, 3);
      CurrentX = 11'd4;
      tick();
      neg(); chk("col1.Pixel", PixelColor, 54); adv();
      scan(5, 8);

      // Draw write during active video, away from a tile change.
      CurrentX = 11'd9;
      DrawReq = 1'b1; DrawWe = 1'b1; DrawAddr = 15'd6000; DrawWrData = 8'hA5;
      req_cyc = cyc; ack_lat = -1; we_cnt = 0;
      tick(); tick();
      scan(10, 11);
      chk("wr.ack_lat_le1", (ack_lat >= 0 && ack_lat <= 1), 1);
      chk("wr.we_cycles", we_cnt, 1);
      chk("wr.ram", mem[6000], 8'hA5);
      chk("wr.req_dropped", DrawReq, 0);

      // Draw read collides with the tile change at X=12.
      CurrentX = 11'd12;
      DrawReq = 1'b1; DrawWe = 1'b0; DrawAddr = 15'd5000;
      neg(); chk("rd.ack_lost", DrawAck, 0); chk("rd.disp_addr", FbAddr, 204); adv();
      neg(); chk("rd.ack_retry", DrawAck, 1); chk("rd.draw_addr", FbAddr, 5000); adv();
      CurrentX = 11'd13;
      neg(); chk("rd.valid", DrawRdValid, 1); chk("rd.data", DrawRdData, 137); adv();
      tick();
      neg(); chk("rd.valid_once", DrawRdValid, 0); adv();
      tick();

      // Rest of the line, then the out-of-range column 200.
      scan(14, 799);
      for (int x = 800; x <= 805; x++) begin
         CurrentX = 11'(x);
         tick();
         neg(); chk("col200.FbAddr", FbAddr, 0); chk("col200.Pixel", PixelColor, 0); adv();
      end
      HBlank = 1'b1; CurrentX = 11'd810;
      tick(); tick();

      // Last line of the frame: prefetch row 0, then VBlank falls.
      HBlank = 1'b0; VBlank = 1'b1; CurrentY = 11'd665; CurrentX = 11'd900;
      tick(); tick();
      HBlank = 1'b1;
      neg(); chk("vlast.FbAddr", FbAddr, 0); chk("vlast.DrawAck", DrawAck, 0); adv();
      tick(); tick();
      HBlank = 1'b0; VBlank = 1'b0; CurrentY = 11'd0; CurrentX = 11'd0;
      neg(); chk("fs.before", FrameStart, 0); chk("fs.FbAddr", FbAddr, 1); adv();
      neg(); chk("fs.pulse", FrameStart, 1); chk("fs.Pixel", PixelColor, 12); adv();
      neg(); chk("fs.after", FrameStart, 0); adv();
      scan(1, 3);

      // Reset lands one cycle after a display grant (row 0, column 2).
      CurrentX = 11'd4;
      neg(); chk("rst.grant", FbAddr, 2); adv();
      Reset = 1'b1;
      tick();
      neg(); chk_all_zero("rst_mid"); adv();
      Reset = 1'b0; CurrentY = 11'd4; CurrentX = 11'd0;
      tick();
      neg(); chk("rst.next_word", PixelColor, 0); chk("rst.no_rdv", DrawRdValid, 0); adv();
      scan(1, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
